sq_cbrt_sum: RTL and testbench

SQ_CBRT_SUM -- requirements
Module: sq_cbrt_sum

---
 rtl/sq_cbrt_sum.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_sq_cbrt_sum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sq_cbrt_sum.sv
`default_nettype none
// ============================================================================
//  Module   : sq_cbrt_sum
//  Purpose  : Computes result = a*a + floor(cbrt(b)) for 8-bit unsigned
//             operands. A shift-add multiplier and an iterative cube-root unit
//             both borrow a single shared 16-bit adder owned by the top level.
//  Options  : SQCB_DONE_EN - adds a one-cycle 'done' pulse after completion.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// sq_mul: 8x8 shift-add multiplier. It owns no adder: each iteration it
// presents {accumulator, shifted multiplicand or 0} on add_a/add_b and takes
// the sum back on add_sum. Eight iterations, one per multiplier bit.
// ----------------------------------------------------------------------------
module sq_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic [15:0] product,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum
);
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [7:0]  bit_sel;   // one-hot iteration marker, avoids a counter adder

  // Load operands on start, then accumulate one partial product per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= 16'd0;
      mplier  <= 8'd0;
      acc     <= 16'd0;
      bit_sel <= 8'd0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= {8'd0, a};
      mplier  <= b;
      acc     <= 16'd0;
      bit_sel <= 8'd1;
      busy    <= 1'b1;
    end else if (busy) begin
      acc     <= add_sum;
      mcand   <= {mcand[14:0], 1'b0};
      mplier  <= {1'b0, mplier[7:1]};
      bit_sel <= {bit_sel[6:0], 1'b0};
      if (bit_sel[7]) busy <= 1'b0;
    end
  end

  assign add_a   = acc;
  assign add_b   = mplier[0] ? mcand : 16'd0;
  assign product = acc;
endmodule

// ----------------------------------------------------------------------------
// sq_cbrt: 8-bit integer cube root by incremental cubes. Keeps
// cube = r^3, delta = (r+1)^3 - r^3 = 3r^2+3r+1 and step = 6(r+1). Each
// candidate takes four adder cycles (cube+delta, delta+step, step+6, r+1);
// it stops as soon as cube+delta exceeds x.
// ----------------------------------------------------------------------------
module sq_cbrt (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x_i,
  output logic        busy,
  output logic [7:0]  root,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum
);
  logic [7:0]  x;
  logic [15:0] cube;
  logic [15:0] delta;
  logic [15:0] step;
  logic [3:0]  phase;     // one-hot sub-step within a candidate

  // Walk candidates upward, one shared-adder operation per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= 8'd0;
      root  <= 8'd0;
      cube  <= 16'd0;
      delta <= 16'd0;
      step  <= 16'd0;
      phase <= 4'd0;
      busy  <= 1'b0;
    end else if (start) begin
      x     <= x_i;
      root  <= 8'd0;
      cube  <= 16'd0;
      delta <= 16'd1;
      step  <= 16'd6;
      phase <= 4'b0001;
      busy  <= 1'b1;
    end else if (busy) begin
      if (phase[0]) begin
        if (add_sum > {8'd0, x}) begin
          busy <= 1'b0;
        end else begin
          cube  <= add_sum;
          phase <= 4'b0010;
        end
      end else if (phase[1]) begin
        delta <= add_sum;
        phase <= 4'b0100;
      end else if (phase[2]) begin
        step  <= add_sum;
        phase <= 4'b1000;
      end else begin
        root  <= add_sum[7:0];
        phase <= 4'b0001;
      end
    end
  end

  // Select the operands for the current sub-step
  always_comb begin
    add_a = 16'd0;
    add_b = 16'd0;
    if (busy) begin
      if (phase[0]) begin
        add_a = cube;
        add_b = delta;
      end else if (phase[1]) begin
        add_a = delta;
        add_b = step;
      end else if (phase[2]) begin
        add_a = step;
        add_b = 16'd6;
      end else if (phase[3]) begin
        add_a = {8'd0, root};
        add_b = 16'd1;
      end
    end
  end
endmodule

// ----------------------------------------------------------------------------
// Top level: sequencer, operand latches and the one shared adder.
// ----------------------------------------------------------------------------
module sq_cbrt_sum (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] result,
  output logic        busy
`ifdef SQCB_DONE_EN
  ,
  output logic        done
`endif
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SQ_RST   = 3'd1;
  localparam logic [2:0] S_SQ_START = 3'd2;
  localparam logic [2:0] S_SQ_RUN   = 3'd3;
  localparam logic [2:0] S_CB_START = 3'd4;
  localparam logic [2:0] S_CB_WAIT  = 3'd5;
  localparam logic [2:0] S_CB_RUN   = 3'd6;
  localparam logic [2:0] S_ADD      = 3'd7;

  logic [2:0]  state;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [15:0] sq;
  logic [15:0] cb;

  logic [15:0] sum_in_a;
  logic [15:0] sum_in_b;
  logic [15:0] sum_out;

  logic        mul_rst;
  logic        mul_start;
  logic        mul_busy;
  logic [15:0] mul_product;
  logic [15:0] mul_add_a;
  logic [15:0] mul_add_b;

  logic        cb_start;
  logic        cb_busy;
  logic [7:0]  cb_root;
  logic [15:0] cb_add_a;
  logic [15:0] cb_add_b;

  // The single shared adder; the maximum result 65031 never wraps
  assign sum_out = sum_in_a + sum_in_b;

  // The multiplier is cleared in SQ_RST so each operation starts from a clean unit
  assign mul_rst   = rst | (state == S_SQ_RST);
  assign mul_start = (state == S_SQ_START);
  assign cb_start  = (state == S_CB_START);
  assign busy      = (state != S_IDLE);

  sq_mul u_mul (
    .clk     (clk),
    .rst     (mul_rst),
    .start   (mul_start),
    .a       (a_reg),
    .b       (a_reg),
    .busy    (mul_busy),
    .product (mul_product),
    .add_a   (mul_add_a),
    .add_b   (mul_add_b),
    .add_sum (sum_out)
  );

  sq_cbrt u_cbrt (
    .clk     (clk),
    .rst     (rst),
    .start   (cb_start),
    .x_i     (b_reg),
    .busy    (cb_busy),
    .root    (cb_root),
    .add_a   (cb_add_a),
    .add_b   (cb_add_b),
    .add_sum (sum_out)
  );

  // Route the adder to whichever unit owns it in the current state
  always_comb begin
    sum_in_a = 16'd0;
    sum_in_b = 16'd0;
    case (state)
      S_SQ_RUN: begin
        sum_in_a = mul_add_a;
        sum_in_b = mul_add_b;
      end
      S_CB_WAIT, S_CB_RUN: begin
        sum_in_a = cb_add_a;
        sum_in_b = cb_add_b;
      end
      S_ADD: begin
        sum_in_a = sq;
        sum_in_b = cb;
      end
      default: begin
        sum_in_a = 16'd0;
        sum_in_b = 16'd0;
      end
    endcase
  end

  // Sequencer: latch operands, run square then cube root, then add
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_reg  <= 8'd0;
      b_reg  <= 8'd0;
      sq     <= 16'd0;
      cb     <= 16'd0;
      result <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a_i;
            b_reg <= b_i;
            state <= S_SQ_RST;
          end
        end
        S_SQ_RST:   state <= S_SQ_START;
        S_SQ_START: state <= S_SQ_RUN;
        S_SQ_RUN: begin
          if (!mul_busy) begin
            sq    <= mul_product;
            state <= S_CB_START;
          end
        end
        S_CB_START: state <= S_CB_WAIT;
        S_CB_WAIT:  state <= S_CB_RUN;
        S_CB_RUN: begin
          if (!cb_busy) begin
            cb    <= {8'd0, cb_root};
            state <= S_ADD;
          end
        end
        S_ADD: begin
          result <= sum_out;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SQCB_DONE_EN
  // One-cycle completion pulse, aligned with the first cycle of the new result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == S_ADD);
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_sq_cbrt_sum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sq_cbrt_sum
//  Purpose  : Self-checking bench for sq_cbrt_sum against an arithmetic model
//             of a*a + floor(cbrt(b)). Honours SQCB_DONE_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sq_cbrt_sum;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic [15:0] result;
  logic        busy;
`ifdef SQCB_DONE_EN
  logic        done;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_result;

  sq_cbrt_sum dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_i    (a_i),
    .b_i    (b_i),
    .result (result),
    .busy   (busy)
`ifdef SQCB_DONE_EN
    ,
    .done   (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: square plus largest r with r^3 <= b
  function automatic logic [31:0] model(input int a, input int b);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return a * a + r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation; optionally scrambles inputs after acceptance or
  // re-pulses start in SQ_RUN (n=4) and CB_RUN (n=16)
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit scramble, input bit repulse);
    int n;
    bit held_ok;
    logic [31:0] prev;
    prev = exp_result;
    @(negedge clk);
    start = 1'b1; a_i = a; b_i = b;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin a_i = 8'd1; b_i = 8'd1; end
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    n = 0;
    held_ok = 1'b1;
    while (busy === 1'b1 && n < 400) begin
      if ({16'd0, result} !== prev) held_ok = 1'b0;
`ifdef SQCB_DONE_EN
      if (done !== 1'b0) held_ok = 1'b0;
`endif
      start = repulse && (n == 4 || n == 16);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_in_time"}, (n < 400) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, "_hold"}, {31'd0, held_ok}, 32'd1);
    exp_result = model(a, b);
    chk({tag, "_result"}, {16'd0, result}, exp_result);
`ifdef SQCB_DONE_EN
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
`endif
    @(negedge clk);
    chk({tag, "_stay_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ha, hb;
    int n;
    bit pulse_ok;

    rst = 1'b1; start = 1'b0; a_i = 8'd0; b_i = 8'd0;
    exp_result = 32'd0;
    @(negedge clk);
    chk("reset_result", {16'd0, result}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    run_op("basic_3_27", 8'd3, 8'd27, 1'b0, 1'b0);
    chk("basic_value", exp_result, 32'd12);
    run_op("max", 8'd255, 8'd255, 1'b0, 1'b0);
    chk("max_value", exp_result, 32'd65031);
    run_op("zero", 8'd0, 8'd0, 1'b0, 1'b0);
    run_op("latched", 8'd10, 8'd64, 1'b1, 1'b0);
    chk("latched_value", exp_result, 32'd104);
    run_op("repulse", 8'd2, 8'd26, 1'b0, 1'b1);
    run_op("pre_rst", 8'd7, 8'd100, 1'b0, 1'b0);

    // Reset in the middle of the cube-root phase
    @(negedge clk);
    start = 1'b1; a_i = 8'd9; b_i = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
`ifdef SQCB_DONE_EN
    chk("rst_done", {31'd0, done}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    exp_result = 32'd0;
    run_op("after_rst", 8'd4, 8'd8, 1'b0, 1'b0);
    chk("after_rst_value", exp_result, 32'd18);

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      run_op("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    // Start held high: back-to-back operations with one IDLE cycle between
    @(negedge clk);
    ha = 8'($urandom_range(0, 255));
    hb = 8'($urandom_range(0, 255));
    start = 1'b1; a_i = ha; b_i = hb;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      n = 0;
      pulse_ok = 1'b1;
      while (busy === 1'b1 && n < 400) begin
`ifdef SQCB_DONE_EN
        if (done !== 1'b0) pulse_ok = 1'b0;
`endif
        @(negedge clk);
        n++;
      end
      chk("b2b_in_time", (n < 400) ? 32'd1 : 32'd0, 32'd1);
      chk("b2b_no_early_done", {31'd0, pulse_ok}, 32'd1);
      exp_result = model(ha, hb);
      chk("b2b_result", {16'd0, result}, exp_result);
`ifdef SQCB_DONE_EN
      chk("b2b_done", {31'd0, done}, 32'd1);
`endif
      if (k < 2) begin
        ha = 8'($urandom_range(0, 255));
        hb = 8'($urandom_range(0, 255));
        a_i = ha; b_i = hb;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end_idle", {31'd0, busy}, 32'd0);
    chk("b2b_end_result", {16'd0, result}, exp_result);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
